// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   localparam logic [31:0] NOP_INST     = 32'h0000_0013;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; used for fetched entries and the in-flight PC queue.
module fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = 2,
   parameter type T = logic [31:0]
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  T                 wdata,
   output T                 rdata,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   T                 mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, rd_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   assign do_pop  = pop & (count_q != '0);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push & ((count_q != FULL) | do_pop);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= wdata;
            wr_q        <= next_ptr(wr_q);
         end
         if (do_pop) rd_q <= next_ptr(rd_q);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign rdata = mem_q[rd_q];
   assign count = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues credit-limited word requests, buffers responses
// for decode and discards stale in-flight fetches after a redirect.
module inst_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned CNT_W    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst
);

   localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(DEPTH);

   logic [31:0]      pc_q;
   logic [CNT_W-1:0] outstanding_q, drop_q;
   logic [CNT_W-1:0] fifo_count, pcq_count;
   logic [31:0]      pcq_head;
   fetch_entry_t     head, push_entry;
   logic             grant, keep, pop, fifo_empty;

   assign fifo_empty = (fifo_count == '0);
   assign imem_req   = ~rst & ~redirect &
                       (({1'b0, fifo_count} + {1'b0, outstanding_q}) < CREDITS);
   assign imem_addr  = pc_q;
   assign grant      = imem_req & imem_gnt;
   // Only responses that belong to the current fetch stream reach the entry FIFO.
   assign keep       = imem_rvalid & (drop_q == '0) & ~redirect & (pcq_count != '0);
   assign push_entry = '{pc: pcq_head, inst: imem_rdata};

   assign if_valid = ~fifo_empty & ~redirect;
   assign pop      = if_valid & if_ready;
   assign if_pc    = fifo_empty ? 32'h0 : head.pc;
   assign if_inst  = fifo_empty ? NOP_INST : head.inst;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         outstanding_q <= outstanding_q + CNT_W'(grant) - CNT_W'(imem_rvalid);
         if (redirect) begin
            pc_q   <= {redirect_pc[31:2], 2'b00};
            // Everything still in flight is stale, whether or not it was already marked.
            drop_q <= outstanding_q - CNT_W'(imem_rvalid);
         end else begin
            if (grant) pc_q <= pc_q + 32'd4;
            if (imem_rvalid && (drop_q != '0)) drop_q <= drop_q - 1'b1;
         end
      end
   end

   fetch_fifo #(
      .DEPTH(DEPTH),
      .CNT_W(CNT_W),
      .T    (fetch_entry_t)
   ) u_entry_fifo (
      .clk  (clk),
      .rst  (rst),
      .flush(redirect),
      .push (keep),
      .pop  (pop),
      .wdata(push_entry),
      .rdata(head),
      .count(fifo_count)
   );

   fetch_fifo #(
      .DEPTH(DEPTH),
      .CNT_W(CNT_W),
      .T    (logic [31:0])
   ) u_pc_queue (
      .clk  (clk),
      .rst  (rst),
      .flush(redirect),
      .push (grant),
      .pop  (keep),
      .wdata(pc_q),
      .rdata(pcq_head),
      .count(pcq_count)
   );

endmodule
